wb_trace_serializer: RTL and testbench
======================================

Name: wb_trace_serializer

Overview:
- Sits directly upstream of the trace compare/logging logic, at the CPU datapath's dual write-back outputs.
- Each cycle it accepts up to two write-back records: slot 0 is older than slot 1.
- It drops records that carry no register write and buffers the rest in program order.
- It emits them one per cycle over a valid/ready stream; this gives a single ordered commit trace for on-chip comparison or UART dumping, plus a retired-record counter.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4.
- FILTER_R0, 1, when 1, records with rd == 0 are dropped like en == 0 records.

Ports:
- sys_clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- wb0_en  in  1  slot 0 write-back enable
- wb0_rd  in  5  slot 0 destination register
- wb0_wdata  in  32  slot 0 write data
- wb0_pc  in  32  slot 0 PC
- wb1_en, wb1_rd, wb1_wdata, wb1_pc  in  1/5/32/32  slot 1, same meaning as slot 0
- in_ready  out  1  buffer can take two records this cycle; the pipeline stalls write-back when low
- out_valid  out  1  head record valid
- out_pc  out  32  head PC
- out_rd  out  5  head rd
- out_wdata  out  32  head data
- out_ready  in  1  consumer accepts head
- level  out  $clog2(DEPTH)+1  occupied entries
- commit_cnt  out  32  accepted records, wraps modulo 2^32
- overflow  out  1  sticky: a record was offered while in_ready was low

Behaviour:
- Reset is synchronous on resetn == 0 at the sys_clk edge. After reset:
  - pointers = 0, level = 0, commit_cnt = 0, overflow = 0;
  - out_valid = 0, out_pc/out_rd/out_wdata = 0, in_ready = 1.
- Reset mid-operation discards all buffered entries. Storage contents need not be cleared.
- Qualify: qN = wbN_en && (!FILTER_R0 || wbN_rd != 0). push_cnt = q0 + q1, range 0..2.
- in_ready = (DEPTH - level) >= 2. It is computed from the registered level only: a pop in the same cycle does not raise in_ready.
- Accept: when in_ready == 1, qualifying records are written at wptr in order.
  - q0 && q1: slot 0 at wptr, slot 1 at wptr+1.
  - Only one qualifies: it goes at wptr.
  - wptr advances by push_cnt, wrapping modulo DEPTH.
- Drop: when in_ready == 0 and push_cnt > 0, all records that cycle are discarded and overflow is set to 1 the next cycle. It stays 1 until reset. commit_cnt is not incremented for dropped records.
- Pop: out_valid && out_ready advances rptr by 1, wrapping.
- Simultaneous push and pop are allowed: level_next = level + accepted_push_cnt - pop. Level never exceeds DEPTH.
- Output:
  - out_valid = (level != 0).
  - out_* is a combinational read of the entry at rptr. It is forced to 0 when level == 0.
  - Latency: a record accepted at edge N is visible on out_* after edge N (one-cycle latency) if the FIFO was empty.
- Ordering: output order is always slot 0 before slot 1 within a cycle, and earlier cycles before later ones.
- commit_cnt += accepted_push_cnt each cycle, with wrap at 2^32.
- Empty with out_ready high: no pop, no pointer change.
- Full (level == DEPTH): in_ready = 0 and out_valid = 1.

Decomposition:
- Shared package trace_pkg:
  - typedef trace_rec_t packed {pc[31:0], rd[4:0], wdata[31:0]};
  - constant TRACE_REC_W = 69.
- Sub-module trace_fifo_2w1r(DEPTH):
  - two write ports with a write count, one read port;
  - owns the storage, wptr, rptr and level.
- The top owns qualification, overflow, commit_cnt and output zeroing.

Test Plan:
- Reset then idle: 20 cycles with en = 0 -> out_valid = 0, level = 0, in_ready = 1, commit_cnt = 0.
- Dual push, one cycle:
  - stimulus: slot 0 {pc=bfc00000, rd=2, wdata=11}, slot 1 {pc=bfc00004, rd=3, wdata=22}, out_ready = 1;
  - response: next cycle out = bfc00000/2/11, the cycle after out = bfc00004/3/22, then out_valid = 0, commit_cnt = 2.
- Filter, FILTER_R0 = 1:
  - stimulus: slot 0 rd = 0, slot 1 {pc=bfc00010, rd=5, wdata=33}, en = 1 on both;
  - response: exactly one record (bfc00010/5/33), commit_cnt = 1.
- Fill and overflow:
  - stimulus: out_ready = 0, 4 cycles of dual pushes with DEPTH = 8 -> level = 8, in_ready = 0;
  - a 5th dual push is dropped: overflow = 1 and commit_cnt = 8;
  - then out_ready = 1 drains 8 records in PC order.
- Concurrent push/pop with wrap:
  - stimulus: out_ready = 1, slot 0 only, pcs 0x100, 0x104, ... for 20 cycles;
  - response: level stays 1, outputs appear in order across pointer wrap, commit_cnt = 20.
- Reset mid-stream:
  - stimulus: level = 5, assert resetn = 0 for 1 cycle;
  - response: level = 0, out_valid = 0, overflow = 0, commit_cnt = 0;
  - a subsequent push appears with one-cycle latency.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared trace record type for the write-back serializer
package trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } trace_rec_t;

    localparam int TRACE_REC_W = 69;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// rtl/trace_fifo_2w1r.sv - circular buffer taking 0..2 records per cycle, draining one
module trace_fifo_2w1r
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       sys_clk,
    input  logic                       resetn,
    input  logic [1:0]                 wr_cnt,
    input  trace_rec_t                 wr_data0,
    input  trace_rec_t                 wr_data1,
    input  logic                       rd_en,
    output trace_rec_t                 rd_data,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    trace_rec_t    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage is never reset; level alone decides what is valid.
    always_ff @(posedge sys_clk) begin
        if (wr_cnt != 2'd0) begin
            mem[wptr] <= wr_data0;
        end
        if (wr_cnt == 2'd2) begin
            mem[wptr + AW'(1)] <= wr_data1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= wptr + AW'(wr_cnt);
            if (rd_en) begin
                rptr <= rptr + AW'(1);
            end
            level <= level + LW'(wr_cnt) - LW'(rd_en);
        end
    end

    assign rd_data = mem[rptr];

endmodule

// File: rtl/wb_trace_serializer.sv
// rtl/wb_trace_serializer.sv - merges dual write-back records into one ordered commit stream
module wb_trace_serializer
    import trace_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter bit FILTER_R0 = 1'b1
) (
    input  logic                   sys_clk,
    input  logic                   resetn,
    input  logic                   wb0_en,
    input  logic [4:0]             wb0_rd,
    input  logic [31:0]            wb0_wdata,
    input  logic [31:0]            wb0_pc,
    input  logic                   wb1_en,
    input  logic [4:0]             wb1_rd,
    input  logic [31:0]            wb1_wdata,
    input  logic [31:0]            wb1_pc,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [31:0]            out_pc,
    output logic [4:0]             out_rd,
    output logic [31:0]            out_wdata,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [31:0]            commit_cnt,
    output logic                   overflow
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic       q0;
    logic       q1;
    logic [1:0] push_cnt;
    logic [1:0] acc_cnt;
    logic       pop;
    trace_rec_t rec0;
    trace_rec_t rec1;
    trace_rec_t first;
    trace_rec_t head;

    assign q0       = wb0_en && (!FILTER_R0 || wb0_rd != 5'd0);
    assign q1       = wb1_en && (!FILTER_R0 || wb1_rd != 5'd0);
    assign push_cnt = {1'b0, q0} + {1'b0, q1};

    // Registered level only, so a same-cycle pop never opens the gate early.
    assign in_ready = (LW'(DEPTH) - level) >= LW'(2);
    assign acc_cnt  = in_ready ? push_cnt : 2'd0;

    assign rec0  = '{pc: wb0_pc, rd: wb0_rd, wdata: wb0_wdata};
    assign rec1  = '{pc: wb1_pc, rd: wb1_rd, wdata: wb1_wdata};
    // A lone slot-1 record still lands at wptr.
    assign first = q0 ? rec0 : rec1;

    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;

    trace_fifo_2w1r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clk  (sys_clk),
        .resetn   (resetn),
        .wr_cnt   (acc_cnt),
        .wr_data0 (first),
        .wr_data1 (rec1),
        .rd_en    (pop),
        .rd_data  (head),
        .level    (level)
    );

    assign out_pc    = out_valid ? head.pc    : 32'd0;
    assign out_rd    = out_valid ? head.rd    : 5'd0;
    assign out_wdata = out_valid ? head.wdata : 32'd0;

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            commit_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            commit_cnt <= commit_cnt + 32'(acc_cnt);
            if (!in_ready && push_cnt != 2'd0) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_serializer.sv
// tb/tb_wb_trace_serializer.sv - directed self-checking bench for wb_trace_serializer
module tb_wb_trace_serializer;

    logic        sys_clk = 1'b0;
    logic        resetn;
    logic        wb0_en, wb1_en;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_wdata, wb1_wdata, wb0_pc, wb1_pc;
    logic        in_ready, out_valid, out_ready, overflow;
    logic [31:0] out_pc, out_wdata, commit_cnt;
    logic [4:0]  out_rd;
    logic [3:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    wb_trace_serializer #(
        .DEPTH     (8),
        .FILTER_R0 (1'b1)
    ) dut (
        .sys_clk    (sys_clk),
        .resetn     (resetn),
        .wb0_en     (wb0_en),
        .wb0_rd     (wb0_rd),
        .wb0_wdata  (wb0_wdata),
        .wb0_pc     (wb0_pc),
        .wb1_en     (wb1_en),
        .wb1_rd     (wb1_rd),
        .wb1_wdata  (wb1_wdata),
        .wb1_pc     (wb1_pc),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_rd     (out_rd),
        .out_wdata  (out_wdata),
        .out_ready  (out_ready),
        .level      (level),
        .commit_cnt (commit_cnt),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic slot0(input logic en, input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd);
        wb0_en = en; wb0_pc = pc; wb0_rd = rd; wb0_wdata = wd;
    endtask

    task automatic slot1(input logic en, input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd);
        wb1_en = en; wb1_pc = pc; wb1_rd = rd; wb1_wdata = wd;
    endtask

    task automatic idle_in();
        slot0(1'b0, 32'd0, 5'd0, 32'd0);
        slot1(1'b0, 32'd0, 5'd0, 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        out_ready = 1'b0;
        idle_in();
        tick();
        tick();
        resetn = 1'b1;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_commit", commit_cnt, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);

        for (int i = 0; i < 20; i++) tick();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_commit", commit_cnt, 32'd0);

        // Dual push in one cycle, consumer always ready
        out_ready = 1'b1;
        slot0(1'b1, 32'hbfc00000, 5'd2, 32'h11);
        slot1(1'b1, 32'hbfc00004, 5'd3, 32'h22);
        tick();
        idle_in();
        chk("dual_level", 32'(level), 32'd2);
        chk("dual_pc0", out_pc, 32'hbfc00000);
        chk("dual_rd0", 32'(out_rd), 32'd2);
        chk("dual_wd0", out_wdata, 32'h11);
        tick();
        chk("dual_pc1", out_pc, 32'hbfc00004);
        chk("dual_rd1", 32'(out_rd), 32'd3);
        chk("dual_wd1", out_wdata, 32'h22);
        tick();
        chk("dual_empty", 32'(out_valid), 32'd0);
        chk("dual_commit", commit_cnt, 32'd2);

        // rd == 0 on slot 0 is filtered; slot 1 alone lands at the head
        slot0(1'b1, 32'hbfc0000c, 5'd0, 32'h99);
        slot1(1'b1, 32'hbfc00010, 5'd5, 32'h33);
        tick();
        idle_in();
        chk("filt_level", 32'(level), 32'd1);
        chk("filt_pc", out_pc, 32'hbfc00010);
        chk("filt_rd", 32'(out_rd), 32'd5);
        chk("filt_wd", out_wdata, 32'h33);
        chk("filt_commit", commit_cnt, 32'd3);
        tick();
        chk("filt_empty", 32'(out_valid), 32'd0);

        // Fill to DEPTH, then a dropped push sets overflow
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slot0(1'b1, 32'h1000 + 32'(8 * i), 5'd1, 32'(i));
            slot1(1'b1, 32'h1004 + 32'(8 * i), 5'd2, 32'(i));
            tick();
        end
        chk("full_level", 32'(level), 32'd8);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_no_ovf_yet", 32'(overflow), 32'd0);
        slot0(1'b1, 32'h2000, 5'd1, 32'd0);
        slot1(1'b1, 32'h2004, 5'd2, 32'd0);
        tick();
        idle_in();
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_commit", commit_cnt, 32'd11);
        chk("ovf_level", 32'(level), 32'd8);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_pc", out_pc, 32'h1000 + 32'(4 * k));
            tick();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_level", 32'(level), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Steady push/pop across pointer wrap
        for (int i = 0; i < 20; i++) begin
            slot0(1'b1, 32'h100 + 32'(4 * i), 5'(i % 31 + 1), 32'(i));
            tick();
            chk("wrap_level", 32'(level), 32'd1);
            chk("wrap_pc", out_pc, 32'h100 + 32'(4 * i));
        end
        idle_in();
        chk("wrap_commit", commit_cnt, 32'd31);
        tick();
        chk("wrap_empty", 32'(level), 32'd0);

        // Reset with entries buffered
        out_ready = 1'b0;
        slot0(1'b1, 32'h300, 5'd1, 32'd1);
        slot1(1'b1, 32'h304, 5'd2, 32'd2);
        tick();
        slot0(1'b1, 32'h308, 5'd3, 32'd3);
        slot1(1'b1, 32'h30c, 5'd4, 32'd4);
        tick();
        slot1(1'b0, 32'd0, 5'd0, 32'd0);
        slot0(1'b1, 32'h310, 5'd5, 32'd5);
        tick();
        idle_in();
        chk("pre_rst_level", 32'(level), 32'd5);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_commit", commit_cnt, 32'd0);
        chk("mid_rst_pc", out_pc, 32'd0);
        out_ready = 1'b1;
        slot0(1'b1, 32'h400, 5'd7, 32'habc);
        tick();
        idle_in();
        chk("post_rst_pc", out_pc, 32'h400);
        chk("post_rst_rd", 32'(out_rd), 32'd7);
        chk("post_rst_wd", out_wdata, 32'habc);
        chk("post_rst_commit", commit_cnt, 32'd1);
        tick();
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
